// File: rtl/fw_rule_matcher_if.sv
// Header-in / result-out handshake bundle between the packet dispatcher
// (master) and the firewall rule matcher (slave).
interface fw_rule_matcher_if #(
    parameter int HEADER_BIT = 104,
    parameter int SLOT_WIDTH = 4,
    parameter int IDX_WIDTH  = 4
);
    logic                  hdr_valid;
    logic                  hdr_ready;
    logic [HEADER_BIT-1:0] hdr_data;
    logic [SLOT_WIDTH-1:0] hdr_slot;
    logic                  res_valid;
    logic                  res_ready;
    logic                  res_unsafe;
    logic [SLOT_WIDTH-1:0] res_slot;
    logic                  res_hit;
    logic [IDX_WIDTH-1:0]  res_hit_idx;

    // dispatcher side: offers headers, consumes results
    modport master (
        output hdr_valid, hdr_data, hdr_slot, res_ready,
        input  hdr_ready, res_valid, res_unsafe, res_slot, res_hit, res_hit_idx
    );

    // matcher side: accepts headers, produces results
    modport slave (
        input  hdr_valid, hdr_data, hdr_slot, res_ready,
        output hdr_ready, res_valid, res_unsafe, res_slot, res_hit, res_hit_idx
    );
endinterface

// File: rtl/fw_rule_matcher.sv
// Firewall rule matcher: takes one 5-tuple header plus slot tag, scans a
// programmable value/mask rule table one entry per cycle (lowest index wins)
// and returns unsafe/hit/index together with the echoed slot tag.
module fw_rule_matcher #(
    parameter int HEADER_BIT     = 104,
    parameter int SLOT_WIDTH     = 4,
    parameter int NUM_RULES      = 8,
    parameter int IDX_WIDTH      = 4,
    parameter bit DEFAULT_UNSAFE = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    fw_rule_matcher_if.slave      bus,
    input  logic                  rule_wr_en,
    input  logic [IDX_WIDTH-1:0]  rule_wr_idx,
    input  logic [HEADER_BIT-1:0] rule_wr_value,
    input  logic [HEADER_BIT-1:0] rule_wr_mask,
    input  logic                  rule_wr_action,
    input  logic                  rule_wr_valid,
    input  logic                  rule_clear
);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        RESULT
    } state_t;

    state_t                state_q, state_d;
    logic [HEADER_BIT-1:0] hdr_q, hdr_d;
    logic [SLOT_WIDTH-1:0] slot_q, slot_d;
    logic [IDX_WIDTH-1:0]  idx_q, idx_d;
    logic                  unsafe_q, unsafe_d;
    logic                  hit_q, hit_d;
    logic [IDX_WIDTH-1:0]  hit_idx_q, hit_idx_d;

    logic [HEADER_BIT-1:0] value_q [NUM_RULES];
    logic [HEADER_BIT-1:0] value_d [NUM_RULES];
    logic [HEADER_BIT-1:0] mask_q  [NUM_RULES];
    logic [HEADER_BIT-1:0] mask_d  [NUM_RULES];
    logic [NUM_RULES-1:0]  action_q, action_d;
    logic [NUM_RULES-1:0]  valid_q, valid_d;

    logic [NUM_RULES-1:0]  match_vec;
    logic                  cur_match;
    logic                  cur_action;
    logic                  last_entry;

    // Rule table update: clear beats write, out-of-range indices hit no entry
    always_comb begin
        value_d  = value_q;
        mask_d   = mask_q;
        action_d = action_q;
        valid_d  = valid_q;
        if (rule_clear) begin
            valid_d = '0;
        end else if (rule_wr_en) begin
            for (int i = 0; i < NUM_RULES; i++) begin
                if (rule_wr_idx == IDX_WIDTH'(i)) begin
                    value_d[i]  = rule_wr_value;
                    mask_d[i]   = rule_wr_mask;
                    action_d[i] = rule_wr_action;
                    valid_d[i]  = rule_wr_valid;
                end
            end
        end
    end

    // Rule table storage; only the valid bits matter after reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_RULES; i++) begin
                value_q[i] <= '0;
                mask_q[i]  <= '0;
            end
            action_q <= '0;
            valid_q  <= '0;
        end else begin
            value_q  <= value_d;
            mask_q   <= mask_d;
            action_q <= action_d;
            valid_q  <= valid_d;
        end
    end

    // Per-entry masked compare against the captured header
    always_comb begin
        match_vec = '0;
        for (int i = 0; i < NUM_RULES; i++) begin
            match_vec[i] = valid_q[i] && (((hdr_q ^ value_q[i]) & mask_q[i]) == '0);
        end
    end

    // Pick out the entry currently under scan
    always_comb begin
        cur_match  = 1'b0;
        cur_action = 1'b0;
        for (int i = 0; i < NUM_RULES; i++) begin
            if (idx_q == IDX_WIDTH'(i)) begin
                cur_match  = match_vec[i];
                cur_action = action_q[i];
            end
        end
    end

    assign last_entry = (idx_q == IDX_WIDTH'(NUM_RULES - 1));

    // Scan FSM next-state and result latching
    always_comb begin
        state_d   = state_q;
        hdr_d     = hdr_q;
        slot_d    = slot_q;
        idx_d     = idx_q;
        unsafe_d  = unsafe_q;
        hit_d     = hit_q;
        hit_idx_d = hit_idx_q;
        case (state_q)
            IDLE: begin
                if (bus.hdr_valid) begin
                    hdr_d   = bus.hdr_data;
                    slot_d  = bus.hdr_slot;
                    idx_d   = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (cur_match) begin
                    unsafe_d  = cur_action;
                    hit_d     = 1'b1;
                    hit_idx_d = idx_q;
                    state_d   = RESULT;
                end else if (last_entry) begin
                    unsafe_d  = DEFAULT_UNSAFE;
                    hit_d     = 1'b0;
                    hit_idx_d = '0;
                    state_d   = RESULT;
                end else begin
                    idx_d = idx_q + IDX_WIDTH'(1);
                end
            end
            RESULT: begin
                if (bus.res_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM and transaction registers; reset drops any in-flight header
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            hdr_q     <= '0;
            slot_q    <= '0;
            idx_q     <= '0;
            unsafe_q  <= 1'b0;
            hit_q     <= 1'b0;
            hit_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            hdr_q     <= hdr_d;
            slot_q    <= slot_d;
            idx_q     <= idx_d;
            unsafe_q  <= unsafe_d;
            hit_q     <= hit_d;
            hit_idx_q <= hit_idx_d;
        end
    end

    assign bus.hdr_ready   = (state_q == IDLE) && !reset;
    assign bus.res_valid   = (state_q == RESULT);
    assign bus.res_unsafe  = unsafe_q;
    assign bus.res_slot    = slot_q;
    assign bus.res_hit     = hit_q;
    assign bus.res_hit_idx = hit_idx_q;

endmodule

// File: tb/tb_fw_rule_matcher.sv
// Testbench for fw_rule_matcher: directed scenarios plus randomized rule
// tables and headers, checked against a behavioural first-match model.
module tb_fw_rule_matcher;

    localparam int HB  = 104;
    localparam int SW  = 4;
    localparam int NR  = 8;
    localparam int IW  = 4;
    localparam bit DEF = 1'b0;

    logic          clk = 1'b0;
    logic          reset;
    logic          rule_wr_en;
    logic [IW-1:0] rule_wr_idx;
    logic [HB-1:0] rule_wr_value;
    logic [HB-1:0] rule_wr_mask;
    logic          rule_wr_action;
    logic          rule_wr_valid;
    logic          rule_clear;

    int checks = 0;
    int errors = 0;

    logic [HB-1:0] m_value [NR];
    logic [HB-1:0] m_mask  [NR];
    bit            m_action[NR];
    bit            m_valid [NR];

    fw_rule_matcher_if #(.HEADER_BIT(HB), .SLOT_WIDTH(SW), .IDX_WIDTH(IW)) bus ();

    fw_rule_matcher #(
        .HEADER_BIT(HB), .SLOT_WIDTH(SW), .NUM_RULES(NR),
        .IDX_WIDTH(IW), .DEFAULT_UNSAFE(DEF)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus),
        .rule_wr_en     (rule_wr_en),
        .rule_wr_idx    (rule_wr_idx),
        .rule_wr_value  (rule_wr_value),
        .rule_wr_mask   (rule_wr_mask),
        .rule_wr_action (rule_wr_action),
        .rule_wr_valid  (rule_wr_valid),
        .rule_clear     (rule_clear)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [HB-1:0] rand_hdr();
        logic [127:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom()};
        return t[HB-1:0];
    endfunction

    function automatic logic [HB-1:0] make_hdr(input logic [15:0] dstpt, input logic [7:0] proto);
        logic [HB-1:0] h;
        h = rand_hdr();
        h[103:88] = dstpt;
        h[7:0]    = proto;
        return h;
    endfunction

    // first valid rule whose cared-about bits equal the header wins
    function automatic void model_lookup(input logic [HB-1:0] h, output bit hit,
                                         output int idx, output bit unsafe);
        hit    = 1'b0;
        idx    = 0;
        unsafe = DEF;
        for (int i = 0; i < NR; i++) begin
            if (!hit && m_valid[i] && ((h & m_mask[i]) == (m_value[i] & m_mask[i]))) begin
                hit    = 1'b1;
                idx    = i;
                unsafe = m_action[i];
            end
        end
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < NR; i++) m_valid[i] = 1'b0;
    endfunction

    task automatic apply_stimulus(input int idx, input logic [HB-1:0] value, input logic [HB-1:0] mask,
                                  input bit action, input bit valid, input bit clear);
        rule_wr_en     = 1'b1;
        rule_wr_idx    = IW'(idx);
        rule_wr_value  = value;
        rule_wr_mask   = mask;
        rule_wr_action = action;
        rule_wr_valid  = valid;
        rule_clear     = clear;
        tick();
        rule_wr_en = 1'b0;
        rule_clear = 1'b0;
        if (clear) begin
            model_clear();
        end else if (idx < NR) begin
            m_value[idx]  = value;
            m_mask[idx]   = mask;
            m_action[idx] = action;
            m_valid[idx]  = valid;
        end
    endtask

    task automatic send_and_check(input logic [HB-1:0] h, input logic [SW-1:0] slot, input int hold);
        bit hit;
        bit unsafe;
        int idx;
        int exp_lat;
        int cycles;
        model_lookup(h, hit, idx, unsafe);
        exp_lat = hit ? idx + 1 : NR;
        check_output("hdr_ready_idle", 32'(bus.hdr_ready), 32'(1));
        bus.hdr_valid = 1'b1;
        bus.hdr_data  = h;
        bus.hdr_slot  = slot;
        tick();
        bus.hdr_valid = 1'b0;
        bus.hdr_data  = rand_hdr();
        bus.hdr_slot  = SW'($urandom);
        check_output("hdr_ready_busy", 32'(bus.hdr_ready), 32'(0));
        cycles = 0;
        while (!bus.res_valid && cycles < 40) begin
            tick();
            cycles++;
        end
        check_output("latency", 32'(cycles), 32'(exp_lat));
        check_output("res_unsafe", 32'(bus.res_unsafe), 32'(unsafe));
        check_output("res_hit", 32'(bus.res_hit), 32'(hit));
        check_output("res_hit_idx", 32'(bus.res_hit_idx), 32'(idx));
        check_output("res_slot", 32'(bus.res_slot), 32'(slot));
        for (int c = 0; c < hold; c++) begin
            bus.hdr_valid = 1'b1;
            bus.hdr_data  = rand_hdr();
            tick();
            check_output("hold_res_valid", 32'(bus.res_valid), 32'(1));
            check_output("hold_hdr_ready", 32'(bus.hdr_ready), 32'(0));
            check_output("hold_fields", {26'(0), bus.res_unsafe, bus.res_hit, bus.res_slot},
                         {26'(0), unsafe, hit, slot});
            check_output("hold_hit_idx", 32'(bus.res_hit_idx), 32'(idx));
        end
        bus.hdr_valid = 1'b0;
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        check_output("post_res_valid", 32'(bus.res_valid), 32'(0));
        check_output("post_hdr_ready", 32'(bus.hdr_ready), 32'(1));
    endtask

    initial begin
        logic [HB-1:0] h;
        logic [HB-1:0] r3_value;
        logic [HB-1:0] r3_mask;
        logic [HB-1:0] v;
        logic [HB-1:0] m;
        int k;

        reset          = 1'b1;
        bus.hdr_valid  = 1'b0;
        bus.hdr_data   = '0;
        bus.hdr_slot   = '0;
        bus.res_ready  = 1'b0;
        rule_wr_en     = 1'b0;
        rule_wr_idx    = '0;
        rule_wr_value  = '0;
        rule_wr_mask   = '0;
        rule_wr_action = 1'b0;
        rule_wr_valid  = 1'b0;
        rule_clear     = 1'b0;
        for (int i = 0; i < NR; i++) begin
            m_value[i]  = '0;
            m_mask[i]   = '0;
            m_action[i] = 1'b0;
            m_valid[i]  = 1'b0;
        end

        tick();
        tick();
        check_output("rst_hdr_ready", 32'(bus.hdr_ready), 32'(0));
        check_output("rst_res_valid", 32'(bus.res_valid), 32'(0));
        check_output("rst_res_fields", {26'(0), bus.res_unsafe, bus.res_hit, bus.res_slot}, 32'(0));
        check_output("rst_res_hit_idx", 32'(bus.res_hit_idx), 32'(0));
        reset = 1'b0;
        tick();

        $display("[TB] empty table default result");
        send_and_check(rand_hdr(), 4'd5, 0);

        $display("[TB] entry 3 protocol/dstpt rule");
        r3_value = '0;
        r3_value[103:88] = 16'h0016;
        r3_value[7:0]    = 8'h06;
        r3_mask = '0;
        r3_mask[103:88] = 16'hFFFF;
        r3_mask[7:0]    = 8'hFF;
        apply_stimulus(3, r3_value, r3_mask, 1'b1, 1'b1, 1'b0);
        h = make_hdr(16'h0016, 8'h06);
        send_and_check(h, 4'd2, 0);
        send_and_check(make_hdr(16'h0017, 8'h06), 4'd4, 0);

        $display("[TB] priority with match-all entry 1 and backpressure");
        apply_stimulus(1, rand_hdr(), '0, 1'b0, 1'b1, 1'b0);
        send_and_check(h, 4'd2, 10);
        send_and_check(h, 4'd9, 0);

        $display("[TB] clear beats simultaneous write");
        apply_stimulus(0, rand_hdr(), '0, 1'b1, 1'b1, 1'b1);
        send_and_check(h, 4'd7, 0);

        $display("[TB] out-of-range write ignored");
        apply_stimulus(12, '0, '0, 1'b1, 1'b1, 1'b0);
        send_and_check(rand_hdr(), 4'd3, 0);

        $display("[TB] last and first entries");
        apply_stimulus(7, r3_value, r3_mask, 1'b1, 1'b1, 1'b0);
        send_and_check(h, 4'd11, 1);
        apply_stimulus(0, r3_value, r3_mask, 1'b0, 1'b1, 1'b0);
        send_and_check(h, 4'd12, 0);

        $display("[TB] randomized tables and headers");
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 1) == 1) begin
                v = rand_hdr();
                m = rand_hdr() & rand_hdr() & rand_hdr();
                if ($urandom_range(0, 7) == 0) m = '0;
                apply_stimulus($urandom_range(0, 9), v, m, 1'($urandom), $urandom_range(0, 3) != 0, 1'b0);
            end
            if ($urandom_range(0, 19) == 0) apply_stimulus(0, '0, '0, 1'b0, 1'b0, 1'b1);
            h = rand_hdr();
            if ($urandom_range(0, 1) == 1) begin
                k = $urandom_range(0, NR - 1);
                h = m_value[k] ^ (rand_hdr() & ~m_mask[k]);
            end
            send_and_check(h, SW'($urandom), $urandom_range(0, 3));
        end

        $display("[TB] asynchronous reset mid-scan");
        apply_stimulus(0, '0, '0, 1'b0, 1'b0, 1'b1);
        apply_stimulus(5, '0, '0, 1'b1, 1'b1, 1'b0);
        bus.hdr_valid = 1'b1;
        bus.hdr_data  = rand_hdr();
        bus.hdr_slot  = 4'd6;
        tick();
        bus.hdr_valid = 1'b0;
        tick();
        tick();
        #2;
        reset = 1'b1;
        #1;
        check_output("midscan_res_valid", 32'(bus.res_valid), 32'(0));
        check_output("midscan_hdr_ready", 32'(bus.hdr_ready), 32'(0));
        tick();
        tick();
        reset = 1'b0;
        model_clear();
        for (int c = 0; c < 8; c++) begin
            tick();
            check_output("after_rst_no_result", 32'(bus.res_valid), 32'(0));
        end
        send_and_check(rand_hdr(), 4'd13, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fw_rule_matcher.md
Name: fw_rule_matcher

Overview:
- Downstream consumer of the packet dispatcher's header-plus-tag output.
- Takes one 104-bit header (5-tuple) plus PRT slot tag at a time and scans a programmable rule table sequentially, one rule per cycle.
- Returns result-plus-tag (unsafe flag, slot) to the dispatcher. The dispatcher uses it to route the slot to its send FIFO or its invalidate FIFO.

Parameters:
- HEADER_BIT, 104, header width; layout {dstpt[103:88], srcpt[87:72], dstip[71:40], srcip[39:8], protocol[7:0]}.
- SLOT_WIDTH, 4, PRT slot tag width.
- NUM_RULES, 8, rule table depth (1..16).
- IDX_WIDTH, 4, rule index width; must satisfy 2^IDX_WIDTH >= NUM_RULES.
- DEFAULT_UNSAFE, 0, result returned when no rule matches.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- hdr_valid  in  1  header+tag offered
- hdr_ready  out  1  matcher can accept a header
- hdr_data  in  HEADER_BIT  packet header
- hdr_slot  in  SLOT_WIDTH  PRT slot tag
- res_valid  out  1  result+tag valid
- res_ready  in  1  dispatcher accepts result
- res_unsafe  out  1  1 = invalidate slot, 0 = send slot
- res_slot  out  SLOT_WIDTH  tag echoed from accepted header
- res_hit  out  1  1 = a rule matched, 0 = default applied
- res_hit_idx  out  IDX_WIDTH  index of the matching rule (0 when res_hit=0)
- rule_wr_en  in  1  write one rule entry
- rule_wr_idx  in  IDX_WIDTH  entry index
- rule_wr_value  in  HEADER_BIT  match value
- rule_wr_mask  in  HEADER_BIT  care mask (1 = compare this bit)
- rule_wr_action  in  1  1 = unsafe on match
- rule_wr_valid  in  1  entry enable
- rule_clear  in  1  invalidate all entries

Behaviour:
- Reset (async, active-high): state IDLE, all rule valid bits 0, hdr_ready=0 while reset is asserted; all res_* outputs 0. A reset mid-scan or mid-result drops the transaction; no result is emitted.
- Rule storage: registered. On rule_wr_en with rule_wr_idx < NUM_RULES, the entry {value, mask, action, valid} is written at the clock edge.
  - Writes with rule_wr_idx >= NUM_RULES are ignored.
  - rule_clear clears all valid bits at the edge and takes priority over a simultaneous rule_wr_en.
  - Writes are allowed in any state. A compare in the same cycle as a write to that entry uses the old contents.
- Match test for entry i: valid[i] && (((hdr_q ^ value[i]) & mask[i]) == 0). A valid entry with mask all-zero matches every header.
- FSM:
  - IDLE:
    - hdr_ready=1, res_valid=0.
    - On hdr_valid, capture hdr_q<=hdr_data and slot_q<=hdr_slot; set idx<=0 and go to SCAN.
  - SCAN:
    - hdr_ready=0. Evaluate entry idx each cycle.
    - On a match: latch unsafe<=action[idx], hit<=1, hit_idx<=idx, then go to RESULT. Lowest index wins.
    - Else, if idx==NUM_RULES-1: latch unsafe<=DEFAULT_UNSAFE, hit<=0, hit_idx<=0, then go to RESULT.
    - Else: idx<=idx+1.
  - RESULT:
    - res_valid=1; res_unsafe, res_slot, res_hit and res_hit_idx are held stable.
    - On res_ready, go to IDLE at that edge.
    - res_valid stays high, with outputs stable, until res_ready is sampled high.
- Latency: header accepted at edge E0; a match on entry k gives res_valid high after edge E0+k+1. No match gives res_valid high after edge E0+NUM_RULES.
- Throughput: one header in flight. hdr_ready is low from the acceptance edge until the result handshake completes. A header can be accepted in the cycle immediately after a res_ready handshake.
- hdr_data and hdr_slot are sampled only on the acceptance edge; later changes have no effect.

Test Plan:
- Reset, then offer a header with the table empty (slot=5) -> hdr_ready=1 in IDLE; res_valid rises 8 cycles after acceptance with res_unsafe=0, res_hit=0, res_slot=5.
- Program entry 3 with value protocol=0x06, dstpt=0x0016, mask covering protocol and dstpt, action=1. Send a header with protocol=0x06, dstpt=0x0016, slot=2 -> res_valid rises 4 cycles after acceptance; res_unsafe=1, res_hit=1, res_hit_idx=3, res_slot=2.
- Priority: program entry 1 (all-zero mask, action=0) and entry 3 as above, then send the same header -> res_hit_idx=1, res_unsafe=0, latency 2 cycles.
- Backpressure: hold res_ready=0 for 10 cycles during RESULT -> res_valid and all result fields stay stable and hdr_ready stays 0. Raise res_ready -> IDLE next cycle; a second header is accepted the cycle after.
- Pulse rule_clear together with rule_wr_en to entry 0 -> all entries invalid; the next header returns the default result.
- Assert reset asynchronously mid-SCAN -> res_valid=0 immediately and no result is emitted. After release, hdr_ready=1 and the table is empty.
